// File: rtl/hls_ap_ctrl_master.sv
// Initiator for the HLS ap_ctrl_hs block protocol: takes a job from a valid/ready channel,
// runs the core with start-until-ready, captures its outputs and returns one result beat.
module hls_ap_ctrl_master #(
    parameter int DATA_W  = 32,
    parameter int N_ARGS  = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N_ARGS*DATA_W-1:0] req_args,
    output logic                     ap_start,
    input  logic                     ap_ready,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    output logic [N_ARGS*DATA_W-1:0] core_args,
    input  logic [DATA_W-1:0]        o1,
    input  logic                     o1_ap_vld,
    input  logic [DATA_W-1:0]        o2,
    input  logic                     o2_ap_vld,
    input  logic [DATA_W-1:0]        ap_return,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_o1,
    output logic [DATA_W-1:0]        rsp_o2,
    output logic [DATA_W-1:0]        rsp_return,
    output logic [2:0]               rsp_flags,
    output logic [CNT_W-1:0]         rsp_cycles,
    output logic                     busy
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    state_t                    state_q;
    logic                      req_ready_q, ap_start_q, rsp_valid_q, busy_q;
    logic [N_ARGS*DATA_W-1:0]  core_args_q;
    logic [DATA_W-1:0]         o1_q, o2_q, ret_q;
    logic                      timeout_q, o1_seen_q, o2_seen_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cycles_q;
    logic                      unused_idle;

    assign unused_idle = ap_idle;

    // Latency counter saturates instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            ap_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            core_args_q <= '0;
            o1_q        <= '0;
            o2_q        <= '0;
            ret_q       <= '0;
            timeout_q   <= 1'b0;
            o1_seen_q   <= 1'b0;
            o2_seen_q   <= 1'b0;
            cnt_q       <= '0;
            cycles_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        core_args_q <= req_args;
                        o1_q        <= '0;
                        o2_q        <= '0;
                        ret_q       <= '0;
                        timeout_q   <= 1'b0;
                        o1_seen_q   <= 1'b0;
                        o2_seen_q   <= 1'b0;
                        cycles_q    <= '0;
                        cnt_q       <= CNT_W'(1);
                        ap_start_q  <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START, WAIT: begin
                    if (o1_ap_vld) begin
                        o1_q      <= o1;
                        o1_seen_q <= 1'b1;
                    end
                    if (o2_ap_vld) begin
                        o2_q      <= o2;
                        o2_seen_q <= 1'b1;
                    end
                    if (state_q == START && ap_ready) ap_start_q <= 1'b0;
                    // Done wins over a timeout landing on the same cycle
                    if (ap_done) begin
                        ret_q       <= ap_return;
                        cycles_q    <= cnt_q;
                        ap_start_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        timeout_q   <= 1'b1;
                        ret_q       <= '0;
                        cycles_q    <= cnt_q;
                        ap_start_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (state_q == START && ap_ready) state_q <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    ap_start_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign ap_start   = ap_start_q;
    assign core_args  = core_args_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_o1     = o1_q;
    assign rsp_o2     = o2_q;
    assign rsp_return = ret_q;
    assign rsp_flags  = {timeout_q, o2_seen_q, o1_seen_q};
    assign rsp_cycles = cycles_q;
    assign busy       = busy_q;

endmodule
